sdram_stream_writer: RTL and testbench

SDRAM_STREAM_WRITER -- requirements
Module: sdram_stream_writer

---
 rtl/sdram_stream_writer.sv | 142 ++++++++++++++
 tb/tb_sdram_stream_writer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_stream_writer
//  Purpose  : Buffers a valid/ready word stream in a small FIFO and drains it
//             as sequential Avalon-MM single-word writes, starting at a
//             latched base address, for a latched word count.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_stream_writer #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   length,
    output logic                busy,
    output logic                done,
    input  logic [DATA_W-1:0]   st_data,
    input  logic                st_valid,
    output logic                st_ready,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;       // address of the next write
    logic [ADDR_W-1:0] remaining_q;  // writes still to be accepted by the slave
    logic [ADDR_W-1:0] pending_q;    // stream beats still allowed into the FIFO
    logic              done_q;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;       // extra MSB distinguishes full from empty
    logic [PTR_W:0]    rd_ptr;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic start_ok;
    logic start_zero;
    logic last_pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // st_ready already excludes full, avm_write already excludes empty, so
    // overflow and underflow cannot happen.
    assign st_ready       = (state == S_RUN) && !fifo_full && (pending_q != '0);
    assign avm_write      = (state == S_RUN) && !fifo_empty;
    assign avm_address    = addr_q;
    assign avm_writedata  = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign avm_byteenable = avm_write ? '1 : '0;
    assign busy           = (state != S_IDLE);
    assign done           = done_q;

    assign push       = st_valid && st_ready;
    assign pop        = avm_write && !avm_waitrequest;
    assign start_ok   = (state == S_IDLE) && start && (length != '0);
    assign start_zero = (state == S_IDLE) && start && (length == '0);
    assign last_pop   = pop && (remaining_q == ADDR_W'(1));

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DONE lasts exactly one cycle
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_RUN;
            S_RUN:   if (last_pop) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Transfer counters, address and the done pulse
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            pending_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= start_zero || last_pop;
            if (start_ok) begin
                addr_q      <= base_addr;
                remaining_q <= length;
                pending_q   <= length;
            end else begin
                if (pop) begin
                    addr_q      <= addr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - ADDR_W'(1);
                end
                if (push) begin
                    pending_q <= pending_q - ADDR_W'(1);
                end
            end
        end
    end

    // FIFO pointers; a reset simply discards whatever is buffered
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; payload needs no reset
    always_ff @(posedge clk_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= st_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_stream_writer
//  Purpose  : Directed self-checking bench for sdram_stream_writer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_stream_writer;

    localparam int AW    = 25;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] length;
    logic          busy;
    logic          done;
    logic [DW-1:0] st_data;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] avm_address;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [1:0]    avm_byteenable;
    logic          avm_waitrequest;

    sdram_stream_writer #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk_clk = ~clk_clk;

    int vectors = 0;
    int miscompares = 0;

    // observation state
    logic [AW-1:0] la [64];
    logic [DW-1:0] ld [64];
    int nlog, cyc_n, done_cnt, done_cyc, first_acc, first_wr, last_wr;
    int occ, acc_cnt, cur_len, stall_cnt, stall_err, ready_err, be_err;
    bit stall_mode, full_seen, busy_seen, write_seen;
    logic [DW-1:0] d0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        nlog = 0; done_cnt = 0; done_cyc = -1; first_acc = -1; first_wr = -1;
        last_wr = -1; stall_err = 0; ready_err = 0; be_err = 0;
        full_seen = 0; busy_seen = 0; write_seen = 0;
    endtask

    // One clock: sample handshakes before the edge, observe after it,
    // then drive the waitrequest pattern for the coming cycle.
    task automatic cyc();
        logic sacc, wacc, stall_chk, rst_pre, exp_ready;
        logic [AW-1:0] a_pre;
        logic [DW-1:0] d_pre;
        rst_pre   = reset_reset;
        sacc      = st_valid && st_ready && !rst_pre;
        wacc      = avm_write && !avm_waitrequest && !rst_pre;
        stall_chk = avm_write && avm_waitrequest && !rst_pre;
        a_pre     = avm_address;
        d_pre     = avm_writedata;
        if (avm_write && avm_byteenable !== 2'b11) be_err++;
        if (wacc && nlog < 64) begin
            la[nlog] = a_pre;
            ld[nlog] = d_pre;
            nlog++;
        end
        @(posedge clk_clk);
        #1;
        cyc_n++;
        if (stall_chk && (avm_write !== 1'b1 || avm_address !== a_pre ||
                          avm_writedata !== d_pre)) stall_err++;
        if (sacc) begin
            st_data = st_data + 1'b1;
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc_n;
        end
        if (wacc) begin
            last_wr = cyc_n;
            if (first_wr < 0) first_wr = cyc_n;
        end
        if (rst_pre) begin
            occ = 0; acc_cnt = 0; cur_len = 0;
        end else begin
            occ = occ + int'(sacc) - int'(wacc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (busy === 1'b1) busy_seen = 1;
        if (avm_write === 1'b1) write_seen = 1;
        exp_ready = busy && !done && (occ < DEPTH) && (acc_cnt < cur_len);
        if (st_ready !== exp_ready) ready_err++;
        if (busy && !done && occ == DEPTH && !st_ready) full_seen = 1;
        if (wacc) stall_cnt = 0;
        if (stall_mode && avm_write && stall_cnt < 3) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            avm_waitrequest = 1'b0;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        cur_len   = int'(l);
        acc_cnt   = 0;
        cyc();
        start     = 1'b0;
    endtask

    task automatic run_until_done(input int bound, input string tag);
        int dstart;
        dstart = done_cnt;
        for (int i = 0; i < bound && done_cnt == dstart; i++) cyc();
        check(tag, 32'(done_cnt - dstart), 32'd1);
    endtask

    initial begin
        reset_reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        st_data = '0; st_valid = 1'b0; avm_waitrequest = 1'b0;
        cyc_n = 0; occ = 0; acc_cnt = 0; cur_len = 0; stall_cnt = 0;
        stall_mode = 0; d0 = '0;
        clear_stats();
        cyc(); cyc();

        // reset state
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_done",     32'(done),        32'd0);
        check("rst_st_ready", 32'(st_ready),    32'd0);
        check("rst_avm_write",32'(avm_write),   32'd0);
        check("rst_address",  32'(avm_address), 32'd0);
        reset_reset = 1'b0;
        cyc();

        // basic transfer, continuous stream, no stalls
        clear_stats();
        st_data = 16'hA000; st_valid = 1'b1;
        do_start(25'h100, 25'd4);
        run_until_done(40, "t1_done");
        check("t1_nwrites",   32'(nlog), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", 32'(la[i]), 32'h100 + 32'(i));
            check("t1_data", 32'(ld[i]), 32'hA000 + 32'(i));
        end
        check("t1_latency",   32'(first_wr - first_acc), 32'd1);
        check("t1_throughput",32'(last_wr - first_wr),   32'd3);
        check("t1_done_cycle",32'(done_cyc - last_wr),   32'd0);
        cyc();
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_done_once", 32'(done_cnt), 32'd1);

        // three-cycle stall on every write; FIFO must fill
        clear_stats();
        st_data = 16'hB000; stall_mode = 1;
        do_start(25'h200, 25'd8);
        run_until_done(200, "t2_done");
        stall_mode = 0;
        cyc();
        check("t2_nwrites",  32'(nlog), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t2_addr", 32'(la[i]), 32'h200 + 32'(i));
            check("t2_data", 32'(ld[i]), 32'hB000 + 32'(i));
        end
        check("t2_stall_stable", 32'(stall_err), 32'd0);
        check("t2_full_seen",    32'(full_seen), 32'd1);

        // address wrap at the top of the address space
        clear_stats();
        st_data = 16'hC000;
        do_start(25'h1FFFFFE, 25'd4);
        run_until_done(40, "t3_done");
        cyc();
        check("t3_nwrites", 32'(nlog), 32'd4);
        check("t3_addr0", 32'(la[0]), 32'h1FFFFFE);
        check("t3_addr1", 32'(la[1]), 32'h1FFFFFF);
        check("t3_addr2", 32'(la[2]), 32'h0);
        check("t3_addr3", 32'(la[3]), 32'h1);

        // zero-length start
        clear_stats();
        do_start(25'h600, 25'd0);
        check("t4_done_next", 32'(done_cyc), 32'(cyc_n));
        for (int i = 0; i < 5; i++) cyc();
        check("t4_done_cnt",   32'(done_cnt),   32'd1);
        check("t4_no_write",   32'(write_seen), 32'd0);
        check("t4_never_busy", 32'(busy_seen),  32'd0);

        // reset in the middle of a transfer, then a fresh transfer
        clear_stats();
        st_data = 16'hD000;
        do_start(25'h300, 25'd10);
        for (int i = 0; i < 50 && nlog < 3; i++) cyc();
        check("t5_three_writes", 32'(nlog), 32'd3);
        reset_reset = 1'b1;
        cyc();
        check("t5_rst_write", 32'(avm_write), 32'd0);
        check("t5_rst_busy",  32'(busy),      32'd0);
        check("t5_rst_done",  32'(done),      32'd0);
        reset_reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        check("t5_no_done", 32'(done_cnt), 32'd0);
        clear_stats();
        d0 = st_data;
        do_start(25'h400, 25'd2);
        run_until_done(40, "t5_done");
        cyc();
        check("t5_nwrites", 32'(nlog), 32'd2);
        check("t5_addr0", 32'(la[0]), 32'h400);
        check("t5_addr1", 32'(la[1]), 32'h401);
        check("t5_data0", 32'(ld[0]), 32'(d0));
        check("t5_data1", 32'(ld[1]), 32'(d0 + 16'd1));

        // start re-pulsed while busy is ignored
        clear_stats();
        st_data = 16'hE000;
        do_start(25'h500, 25'd3);
        base_addr = 25'h900; length = 25'd7; start = 1'b1;
        cyc();
        start = 1'b0;
        run_until_done(40, "t6_done");
        for (int i = 0; i < 5; i++) cyc();
        check("t6_nwrites", 32'(nlog), 32'd3);
        check("t6_addr0", 32'(la[0]), 32'h500);
        check("t6_addr1", 32'(la[1]), 32'h501);
        check("t6_addr2", 32'(la[2]), 32'h502);
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_idle_busy", 32'(busy), 32'd0);

        // whole-run checks of ready behaviour and byte enables
        check("ready_model", 32'(ready_err), 32'd0);
        check("byteenable",  32'(be_err),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
